// File: rtl/uart_baud_gen.sv
// uart_baud_gen: programmable baud tick generator for the UART shift engines.
// Produces an oversample strobe (o_rx_tick) and a bit strobe (o_tx_tick) from a
// fixed-point integer.fraction divisor. The divisor is double-buffered, so a
// reload only takes effect at an rx-tick boundary.
// Optional macro UART_BAUD_SQUARE_CLK_EN adds o_tx_clk / o_rx_clk square-wave
// outputs that toggle on each tx / rx tick.
module uart_baud_gen #(
    parameter int CLK_RATE   = 150000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int FRAC_BITS  = 4,
    // Physical width of the fractional datapath; 1 when FRAC_BITS is 0
    // (the bit is then tied to zero and never produces a carry).
    parameter int FW         = (FRAC_BITS > 0) ? FRAC_BITS : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic                 i_div_load,
    input  logic [DIV_WIDTH-1:0] i_div_int,
    input  logic [FW-1:0]        i_div_frac,
    output logic                 o_rx_tick,
    output logic                 o_tx_tick,
    output logic                 o_div_err
`ifdef UART_BAUD_SQUARE_CLK_EN
    ,
    output logic                 o_tx_clk,
    output logic                 o_rx_clk
`endif
);

    localparam int OSC_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [OSC_W-1:0] OSC_MAX = OSC_W'(OVERSAMPLE - 1);

    // Reset-default divisor: clocks per rx tick as integer + truncated fraction.
    localparam longint TICK_RATE  = longint'(BAUD_RATE) * longint'(OVERSAMPLE);
    localparam longint DEF_INT_L  = longint'(CLK_RATE) / TICK_RATE;
    localparam longint DEF_FRAC_L = (FRAC_BITS > 0) ?
        (((longint'(CLK_RATE) % TICK_RATE) << FRAC_BITS) / TICK_RATE) : 64'sd0;
    localparam logic [DIV_WIDTH-1:0] DEF_INT  = DIV_WIDTH'(DEF_INT_L);
    localparam logic [FW-1:0]        DEF_FRAC = FW'(DEF_FRAC_L);

    logic [DIV_WIDTH:0]   count;
    logic [FW-1:0]        acc;
    logic [OSC_W-1:0]     osc;
    logic [DIV_WIDTH-1:0] act_int;
    logic [DIV_WIDTH-1:0] shd_int;
    logic [FW-1:0]        act_frac;
    logic [FW-1:0]        shd_frac;

    logic [FW:0]          acc_sum;
    logic                 carry;
    logic [DIV_WIDTH:0]   period_m1;
    logic                 boundary;
    logic                 load_ok;
    logic                 load_bad;
    logic [FW-1:0]        frac_in;

    // Period of the current rx tick and the boundary / load qualification.
    always_comb begin
        frac_in   = (FRAC_BITS > 0) ? i_div_frac : '0;
        acc_sum   = {1'b0, acc} + {1'b0, act_frac};
        carry     = (FRAC_BITS > 0) ? acc_sum[FW] : 1'b0;
        period_m1 = {1'b0, act_int} + {{DIV_WIDTH{1'b0}}, carry}
                    - (DIV_WIDTH + 1)'(1);
        boundary  = i_en && (count == period_m1);
        load_ok   = i_div_load && (i_div_int >= DIV_WIDTH'(2));
        load_bad  = i_div_load && (i_div_int <  DIV_WIDTH'(2));
    end

    // Cycle counter, fractional accumulator, oversample counter and tick strobes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count     <= '0;
            acc       <= '0;
            osc       <= '0;
            o_rx_tick <= 1'b0;
            o_tx_tick <= 1'b0;
        end else if (!i_en) begin
            count     <= '0;
            acc       <= '0;
            osc       <= '0;
            o_rx_tick <= 1'b0;
            o_tx_tick <= 1'b0;
        end else begin
            o_rx_tick <= boundary;
            o_tx_tick <= boundary && (osc == OSC_MAX);
            if (boundary) begin
                count <= '0;
                acc   <= acc_sum[FW-1:0];
                osc   <= (osc == OSC_MAX) ? '0 : osc + 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    // Shadow/active divisor: active only changes at a boundary or while idle,
    // so a period in progress always finishes with the divisor it started with.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            act_int   <= DEF_INT;
            act_frac  <= DEF_FRAC;
            shd_int   <= DEF_INT;
            shd_frac  <= DEF_FRAC;
            o_div_err <= 1'b0;
        end else begin
            o_div_err <= load_bad;
            if (load_ok) begin
                shd_int  <= i_div_int;
                shd_frac <= frac_in;
            end
            if (!i_en || boundary) begin
                act_int  <= load_ok ? i_div_int : shd_int;
                act_frac <= load_ok ? frac_in   : shd_frac;
            end
        end
    end

`ifdef UART_BAUD_SQUARE_CLK_EN
    // Legacy square-wave clocks: toggle per tick, hold their level while idle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rx_clk <= 1'b0;
            o_tx_clk <= 1'b0;
        end else begin
            if (boundary)
                o_rx_clk <= ~o_rx_clk;
            if (boundary && (osc == OSC_MAX))
                o_tx_clk <= ~o_tx_clk;
        end
    end
`endif

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed testbench for uart_baud_gen using a 1600 Hz clock, 10 baud and
// 16x oversampling, which gives a default divisor of exactly 10.0.
module tb_uart_baud_gen;

    logic        clk;
    logic        rst;
    logic        en;
    logic        div_load;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        rx_tick;
    logic        tx_tick;
    logic        div_err;
`ifdef UART_BAUD_SQUARE_CLK_EN
    logic        tx_clk;
    logic        rx_clk;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_t   = 0;

    uart_baud_gen #(
        .CLK_RATE   (1600),
        .BAUD_RATE  (10),
        .OVERSAMPLE (16),
        .DIV_WIDTH  (16),
        .FRAC_BITS  (4)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_div_load (div_load),
        .i_div_int  (div_int),
        .i_div_frac (div_frac),
        .o_rx_tick  (rx_tick),
        .o_tx_tick  (tx_tick),
        .o_div_err  (div_err)
`ifdef UART_BAUD_SQUARE_CLK_EN
        ,
        .o_tx_clk   (tx_clk),
        .o_rx_clk   (rx_clk)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d required <100000", cyc);
        $fatal(1);
    end

    // Waits for the next rx tick; returns cycles since the previous reference
    // point, or -1 when no tick arrives within the budget.
    task automatic measure_interval(output int iv);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (rx_tick === 1'b1) seen = 1'b1;
        end
        if (seen) begin
            iv     = cyc - last_t;
            last_t = cyc;
        end else begin
            iv = -1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({rx_tick, tx_tick, div_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 000", {rx_tick, tx_tick, div_err});
        end
`ifdef UART_BAUD_SQUARE_CLK_EN
        n_checks++;
        if ({rx_clk, tx_clk} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_sqclk: got %b required 00", {rx_clk, tx_clk});
        end
`endif
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rx_tick, tx_tick, div_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_outputs: got %b required 000", {rx_tick, tx_tick, div_err});
        end
    endtask

    task automatic test_default_rate();
        int iv;
        en     = 1'b1;
        last_t = cyc;
        for (int i = 1; i <= 32; i++) begin
            measure_interval(iv);
            n_checks++;
            if (iv !== 10) begin
                n_fail++;
                $display("FAIL default_interval[%0d]: got %0d required 10", i, iv);
            end
            n_checks++;
            if (tx_tick !== ((i % 16) == 0)) begin
                n_fail++;
                $display("FAIL default_tx_tick[%0d]: got %b required %b", i, tx_tick, (i % 16) == 0);
            end
        end
    endtask

    task automatic test_fractional();
        int iv;
        int sum;
        en = 1'b0;
        @(negedge clk);
        div_load = 1'b1; div_int = 16'd10; div_frac = 4'd8;
        @(negedge clk);
        div_load = 1'b0;
        en     = 1'b1;
        last_t = cyc;
        sum    = 0;
        for (int i = 0; i < 16; i++) begin
            measure_interval(iv);
            sum += iv;
            n_checks++;
            if (iv !== (((i % 2) == 0) ? 10 : 11)) begin
                n_fail++;
                $display("FAIL frac_interval[%0d]: got %0d required %0d", i, iv, ((i % 2) == 0) ? 10 : 11);
            end
        end
        n_checks++;
        if (sum !== 168) begin
            n_fail++;
            $display("FAIL frac_sum16: got %0d required 168", sum);
        end
        // Back to 10.0 for the following scenarios.
        en = 1'b0;
        div_load = 1'b1; div_int = 16'd10; div_frac = 4'd0;
        @(negedge clk);
        div_load = 1'b0;
        en     = 1'b1;
        last_t = cyc;
        measure_interval(iv);
        n_checks++;
        if (iv !== 10) begin
            n_fail++;
            $display("FAIL restore_interval: got %0d required 10", iv);
        end
    endtask

    task automatic test_reload();
        int iv;
        // Load 4 at cycle 3 of a running 10-cycle period.
        repeat (3) @(negedge clk);
        div_load = 1'b1; div_int = 16'd4;
        @(negedge clk);
        div_load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            measure_interval(iv);
            n_checks++;
            if (iv !== ((i == 0) ? 10 : 4)) begin
                n_fail++;
                $display("FAIL reload_interval[%0d]: got %0d required %0d", i, iv, (i == 0) ? 10 : 4);
            end
        end
        // Load 6 exactly on the boundary edge of a 4-cycle period.
        repeat (3) @(negedge clk);
        div_load = 1'b1; div_int = 16'd6;
        measure_interval(iv);
        div_load = 1'b0;
        n_checks++;
        if (iv !== 4) begin
            n_fail++;
            $display("FAIL boundary_load_cur: got %0d required 4", iv);
        end
        measure_interval(iv);
        n_checks++;
        if (iv !== 6) begin
            n_fail++;
            $display("FAIL boundary_load_next: got %0d required 6", iv);
        end
        // Two loads inside one period: the second one is used.
        @(negedge clk);
        div_load = 1'b1; div_int = 16'd8;
        @(negedge clk);
        div_int = 16'd10;
        @(negedge clk);
        div_load = 1'b0;
        measure_interval(iv);
        n_checks++;
        if (iv !== 6) begin
            n_fail++;
            $display("FAIL two_loads_cur: got %0d required 6", iv);
        end
        measure_interval(iv);
        n_checks++;
        if (iv !== 10) begin
            n_fail++;
            $display("FAIL two_loads_next: got %0d required 10", iv);
        end
    endtask

    task automatic test_invalid_load();
        int iv;
        div_load = 1'b1; div_int = 16'd1;
        n_checks++;
        if (div_err !== 1'b0) begin
            n_fail++;
            $display("FAIL div_err_early: got %b required 0", div_err);
        end
        @(negedge clk);
        div_load = 1'b0;
        n_checks++;
        if (div_err !== 1'b1) begin
            n_fail++;
            $display("FAIL div_err_pulse: got %b required 1", div_err);
        end
        @(negedge clk);
        n_checks++;
        if (div_err !== 1'b0) begin
            n_fail++;
            $display("FAIL div_err_width: got %b required 0", div_err);
        end
        for (int i = 0; i < 2; i++) begin
            measure_interval(iv);
            n_checks++;
            if (iv !== 10) begin
                n_fail++;
                $display("FAIL invalid_interval[%0d]: got %0d required 10", i, iv);
            end
        end
    endtask

    task automatic test_enable_mid();
        int iv;
        int ticks;
        repeat (5) @(negedge clk);
        en    = 1'b0;
        ticks = 0;
        repeat (20) begin
            @(negedge clk);
            if (rx_tick === 1'b1) ticks++;
        end
        n_checks++;
        if (ticks !== 0) begin
            n_fail++;
            $display("FAIL disabled_ticks: got %0d required 0", ticks);
        end
        en     = 1'b1;
        last_t = cyc;
        for (int i = 1; i <= 16; i++) begin
            measure_interval(iv);
            n_checks++;
            if (iv !== 10) begin
                n_fail++;
                $display("FAIL reenable_interval[%0d]: got %0d required 10", i, iv);
            end
            n_checks++;
            if (tx_tick !== (i == 16)) begin
                n_fail++;
                $display("FAIL reenable_tx_tick[%0d]: got %b required %b", i, tx_tick, i == 16);
            end
        end
    endtask

    task automatic test_reset_mid();
        int iv;
        div_load = 1'b1; div_int = 16'd4;
        @(negedge clk);
        div_load = 1'b0;
        measure_interval(iv);
        n_checks++;
        if (iv !== 10) begin
            n_fail++;
            $display("FAIL pre_reset_old: got %0d required 10", iv);
        end
        measure_interval(iv);
        n_checks++;
        if (iv !== 4) begin
            n_fail++;
            $display("FAIL pre_reset_new: got %0d required 4", iv);
        end
        // rx_tick is high right now; reset must drop it without a clock edge.
        rst = 1'b1;
        #1;
        n_checks++;
        if ({rx_tick, tx_tick, div_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL async_reset: got %b required 000", {rx_tick, tx_tick, div_err});
        end
        @(negedge clk);
        rst    = 1'b0;
        last_t = cyc;
        measure_interval(iv);
        n_checks++;
        if (iv !== 10) begin
            n_fail++;
            $display("FAIL reset_default_div: got %0d required 10", iv);
        end
    endtask

`ifdef UART_BAUD_SQUARE_CLK_EN
    task automatic test_square_clk();
        int iv;
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({rx_clk, tx_clk} !== 2'b00) begin
            n_fail++;
            $display("FAIL sq_start_low: got %b required 00", {rx_clk, tx_clk});
        end
        en     = 1'b1;
        last_t = cyc;
        for (int i = 1; i <= 31; i++) begin
            measure_interval(iv);
            n_checks++;
            if (iv !== 10) begin
                n_fail++;
                $display("FAIL sq_interval[%0d]: got %0d required 10", i, iv);
            end
            n_checks++;
            if (rx_clk !== ((i % 2) == 1)) begin
                n_fail++;
                $display("FAIL sq_rx_clk[%0d]: got %b required %b", i, rx_clk, (i % 2) == 1);
            end
            n_checks++;
            if (tx_clk !== (i >= 16)) begin
                n_fail++;
                $display("FAIL sq_tx_clk[%0d]: got %b required %b", i, tx_clk, i >= 16);
            end
        end
        en = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rx_clk, tx_clk} !== 2'b11) begin
            n_fail++;
            $display("FAIL sq_hold: got %b required 11", {rx_clk, tx_clk});
        end
    endtask
`endif

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        div_load = 1'b0;
        div_int  = 16'd0;
        div_frac = 4'd0;
        test_reset();
        test_default_rate();
        test_fractional();
        test_reload();
        test_invalid_load();
        test_enable_mid();
        test_reset_mid();
`ifdef UART_BAUD_SQUARE_CLK_EN
        test_square_clk();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
Parametrised, runtime-programmable baud tick generator for the UART TX/RX paths.
- Produces a 1-cycle oversample strobe (o_rx_tick) at OVERSAMPLE x baud and a 1-cycle bit strobe (o_tx_tick) at baud.
- Uses a fixed-point integer.fraction divisor to limit long-term rate error.
- Divisor is reloadable at runtime without glitching the tick stream.
- Sits between the system clock domain and the uart_tx / uart_rx shift engines.

Parameters:
- CLK_RATE, 150000000, input clock frequency in Hz.
- BAUD_RATE, 9600, reset-default baud rate.
- OVERSAMPLE, 16, rx ticks per tx tick; must be >= 2.
- DIV_WIDTH, 16, width of the integer divisor part.
- FRAC_BITS, 4, width of the fractional divisor part (0 allowed: no fractional logic).

Ports:
- i_clk  in  1  system clock, all logic on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_en  in  1  generator enable.
- i_div_load  in  1  1-cycle strobe; captures i_div_int/i_div_frac.
- i_div_int  in  DIV_WIDTH  integer part of clocks per rx tick.
- i_div_frac  in  FRAC_BITS  fractional part, in units of 1/2^FRAC_BITS.
- o_rx_tick  out  1  1-cycle pulse, OVERSAMPLE x baud.
- o_tx_tick  out  1  1-cycle pulse, baud.
- o_div_err  out  1  1-cycle pulse when a load is rejected.
- o_tx_clk  out  1  square wave (SQUARE_CLK_EN only).
- o_rx_clk  out  1  square wave (SQUARE_CLK_EN only).

Behaviour:
- Clock and reset: one clock (i_clk); reset i_rst is asynchronous and active-high.
- Reset values:
  - All outputs 0; cycle counter, fractional accumulator and oversample counter 0.
  - Active and shadow divisor = DEF_INT / DEF_FRAC.
  - DEF_INT = CLK_RATE / (BAUD_RATE*OVERSAMPLE), integer division.
  - DEF_FRAC = ((CLK_RATE mod (BAUD_RATE*OVERSAMPLE)) << FRAC_BITS) / (BAUD_RATE*OVERSAMPLE), truncated.
  - Defaults: 976 / 9.
- Period: P = div_int + carry. carry is the overflow of acc + div_frac (FRAC_BITS-wide accumulator).
  - acc updates only on rx tick cycles.
  - Average period over 2^FRAC_BITS ticks is exactly div_int + div_frac/2^FRAC_BITS.
- i_en = 0: counters, accumulator and oversample counter are held at 0; ticks stay 0. The divisor is still loadable.
- i_en = 1:
  - The cycle counter counts 0..P-1.
  - On the edge where count == P-1: count <= 0, o_rx_tick <= 1 (registered), acc updated.
  - First o_rx_tick is high in cycle P after i_en is first sampled high.
- Oversample counter: advances on each rx tick and wraps at OVERSAMPLE-1. o_tx_tick is asserted in the same cycle as the rx tick that wraps it, i.e. every OVERSAMPLE-th rx tick.
- Divisor load:
  - i_div_load with i_div_int >= 2 writes the shadow register.
  - The shadow is copied to the active divisor at the next rx-tick boundary (the count == P-1 edge), or immediately if i_en = 0.
  - A period in progress always completes with the old divisor.
  - i_div_int < 2: load is ignored and o_div_err pulses for 1 cycle (registered, the cycle after the strobe).
- Simultaneous load and boundary in the same cycle: the new value is used for the next period (shadow and active both take the new value).
- Two loads before a boundary: the last one wins.
- i_en deasserted mid-period: counters clear on the next edge; no partial tick is emitted.
- i_rst mid-operation: immediate return to reset state, including the divisor reverting to default.
- Wrap-around: count width = DIV_WIDTH+1; P never exceeds 2^DIV_WIDTH, so there is no overflow.

Optional Feature:
Macro: UART_BAUD_SQUARE_CLK_EN.
- Defined:
  - o_tx_clk toggles on each o_tx_tick; o_rx_clk toggles on each o_rx_tick.
  - Both are 0 at reset and held (not cleared) while i_en = 0.
  - Gives 50%-duty square waves at baud/2 and OVERSAMPLE x baud/2 for legacy consumers.
- Undefined: ports o_tx_clk / o_rx_clk and their toggle flops are absent.

Test Plan:
- Default rate: CLK_RATE=1600, BAUD_RATE=10, OVERSAMPLE=16, FRAC_BITS=4, i_en=1 after reset -> default divisor 10.0; o_rx_tick every 10 cycles, first in cycle 10 after en; o_tx_tick every 160 cycles, coincident with every 16th rx tick.
- Fractional: load int=10, frac=8 while disabled, enable -> rx intervals alternate 10,11,10,11,...; 16 rx ticks take exactly 168 cycles.
- Glitch-free reload: running at 10.0, load int=4 mid-period (cycle 3) -> current interval stays 10; following intervals are 4.
- Invalid load: i_div_load with int=1 -> o_div_err high 1 cycle later; intervals unchanged at 10.
- Enable/reset mid-operation: drop i_en at cycle 5 of a period -> no rx tick. Re-enable -> first tick after a full P, oversample phase restarted (tx tick after 16 rx ticks). Assert i_rst -> all outputs 0 immediately and divisor back to default.
- With UART_BAUD_SQUARE_CLK_EN: default config -> o_rx_clk period 20 cycles and o_tx_clk period 320 cycles, 50% duty, both starting low.
